// File: rtl/sample_writer_if.sv
// Capture-side bus of the sample memory writer: activate/done handshake, ADC sample strobe,
// RAM write port and trigger status.
interface sample_writer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();
   logic              activate;
   logic              done;
   logic [DATA_W-1:0] adc_data;
   logic              adc_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_we;
   logic [ADDR_W-1:0] trig_addr;
   logic              triggered;

   modport master (
      output activate, adc_data, adc_valid,
      input  done, mem_addr, mem_data, mem_we, trig_addr, triggered
   );

   modport slave (
      input  activate, adc_data, adc_valid,
      output done, mem_addr, mem_data, mem_we, trig_addr, triggered
   );
endinterface

// File: rtl/sample_writer.sv
// Decimates ADC samples and writes a trigger-aligned record of 2**ADDR_W samples into the
// sample RAM as a ring buffer, then holds done until activate is released.
module sample_writer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEC_W  = 16
) (
   input  logic              clk_50mhz,
   input  logic              reset,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   input  logic              force_trig,
   input  logic [ADDR_W-1:0] pretrig,
   input  logic [DEC_W-1:0]  decim,
   sample_writer_if.slave    bus
);

   typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, POST, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] level_l;
   logic              rising_l;
   logic [ADDR_W-1:0] pretrig_l;
   logic [DEC_W-1:0]  decim_l;
   logic [DEC_W-1:0]  dec_cnt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] prev;
   logic              prev_valid;

   logic capturing;
   logic accept;
   logic crossed;
   logic hit;

   // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
   always_comb begin
      capturing = (state == ARM) || (state == WAIT_TRIG) || (state == POST);
      accept    = capturing && bus.adc_valid && (dec_cnt == '0);
      if (rising_l) crossed = prev_valid && (prev < level_l) && (bus.adc_data >= level_l);
      else          crossed = prev_valid && (prev > level_l) && (bus.adc_data <= level_l);
      hit = force_trig || crossed;
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         state         <= IDLE;
         bus.done      <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.triggered <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_data  <= '0;
         bus.trig_addr <= '0;
         level_l       <= '0;
         rising_l      <= 1'b0;
         pretrig_l     <= '0;
         decim_l       <= '0;
         dec_cnt       <= '0;
         wr_ptr        <= '0;
         cnt           <= '0;
         prev          <= '0;
         prev_valid    <= 1'b0;
      end else begin
         bus.mem_we <= 1'b0;
         if (capturing && !bus.activate) begin
            // Abort: any sample accepted in this cycle is dropped.
            state         <= IDLE;
            bus.triggered <= 1'b0;
         end else begin
            if (capturing && bus.adc_valid)
               dec_cnt <= (dec_cnt == '0) ? decim_l : dec_cnt - DEC_W'(1);
            if (accept) begin
               bus.mem_we   <= 1'b1;
               bus.mem_addr <= wr_ptr;
               bus.mem_data <= bus.adc_data;
               wr_ptr       <= wr_ptr + ADDR_W'(1);
               prev         <= bus.adc_data;
               prev_valid   <= 1'b1;
            end
            case (state)
               IDLE: begin
                  if (bus.activate) begin
                     level_l       <= trig_level;
                     rising_l      <= trig_rising;
                     pretrig_l     <= pretrig;
                     decim_l       <= decim;
                     wr_ptr        <= '0;
                     dec_cnt       <= '0;
                     prev_valid    <= 1'b0;
                     cnt           <= '0;
                     bus.triggered <= 1'b0;
                     state         <= (pretrig == '0) ? WAIT_TRIG : ARM;
                  end
               end
               ARM: begin
                  if (accept) begin
                     if (cnt == pretrig_l - ADDR_W'(1)) state <= WAIT_TRIG;
                     else                               cnt   <= cnt + ADDR_W'(1);
                  end
               end
               WAIT_TRIG: begin
                  if (accept && hit) begin
                     bus.trig_addr <= wr_ptr - pretrig_l;
                     bus.triggered <= 1'b1;
                     // Samples still owed after the trigger sample: DEPTH - pretrig - 1.
                     cnt           <= '1 - pretrig_l;
                     state         <= (pretrig_l == '1) ? DONE : POST;
                  end
               end
               POST: begin
                  if (accept) begin
                     cnt <= cnt - ADDR_W'(1);
                     if (cnt == ADDR_W'(1)) state <= DONE;
                  end
               end
               DONE: begin
                  if (!bus.activate) begin
                     state         <= IDLE;
                     bus.done      <= 1'b0;
                     bus.triggered <= 1'b0;
                  end else begin
                     bus.done <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
